// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 modified-Booth recoder: digit codes
// and the digit-count helper used to size the recoder ports.
package booth_pkg;

    // Digit codes are {sign, q1, q0}; q1 selects 2x, q0 selects 1x.
    localparam logic [2:0] BOOTH_ZERO = 3'b000;
    localparam logic [2:0] BOOTH_P1   = 3'b001;
    localparam logic [2:0] BOOTH_P2   = 3'b010;
    localparam logic [2:0] BOOTH_M1   = 3'b101;
    localparam logic [2:0] BOOTH_M2   = 3'b110;

    // One digit per bit pair, plus one extension digit so that an unsigned
    // operand with its MSB set is still represented exactly.
    function automatic int booth_ndig(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Single radix-4 Booth digit: maps the triplet (b[2k+1], b[2k], b[2k-1])
// to a {sign, q1, q0} code. Zero is always emitted as 000, never as -0.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] i_trip,
    output logic [2:0] o_code
);

    // Pure lookup of the recoding table.
    always_comb begin
        o_code = BOOTH_ZERO;
        case (i_trip)
            3'b000:  o_code = BOOTH_ZERO;
            3'b001:  o_code = BOOTH_P1;
            3'b010:  o_code = BOOTH_P1;
            3'b011:  o_code = BOOTH_P2;
            3'b100:  o_code = BOOTH_M2;
            3'b101:  o_code = BOOTH_M1;
            3'b110:  o_code = BOOTH_M1;
            default: o_code = BOOTH_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_enc_pipe.sv
// Parametrised radix-4 Booth recoder with one registered valid/ready output
// stage. Signed/unsigned mode and a sideband tag are sampled per transaction;
// a per-digit non-zero mask accompanies each result.
module booth_enc_pipe
    import booth_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int TAG_W = 4,
    localparam int NDIG  = booth_ndig(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_signed,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3*NDIG-1:0]   out_dig,
    output logic [NDIG-1:0]     out_nz,
    output logic [TAG_W-1:0]    out_tag
);

    logic                w_ext;
    logic [WIDTH+2:0]    w_bits;
    logic [3*NDIG-1:0]   w_dig;
    logic [NDIG-1:0]     w_nz;
    logic                w_take;

    logic                r_vld_p1;
    logic [3*NDIG-1:0]   r_dig_p1;
    logic [NDIG-1:0]     r_nz_p1;
    logic [TAG_W-1:0]    r_tag_p1;

    // Bits above the operand replicate the sign in signed mode, else zero.
    // w_bits[j] holds b[j-1], so b[-1]=0 sits at index 0.
    assign w_ext  = in_signed & in_data[WIDTH-1];
    assign w_bits = {w_ext, w_ext, in_data, 1'b0};

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        booth_digit_enc u_enc (
            .i_trip (w_bits[2*k+2 -: 3]),
            .o_code (w_dig[3*k +: 3])
        );
        assign w_nz[k] = w_dig[3*k+1] | w_dig[3*k];
    end

    // Stage is free when empty or being drained this cycle; flush does not gate it.
    assign in_ready = !r_vld_p1 || out_ready;
    assign w_take   = in_valid && in_ready && !flush;

    // ---- output stage (p1) ----

    // Valid flag: flush wins, then capture, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_take) begin
            r_vld_p1 <= 1'b1;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // Result registers load only on a capture and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig_p1 <= '0;
            r_nz_p1  <= '0;
            r_tag_p1 <= '0;
        end else if (w_take) begin
            r_dig_p1 <= w_dig;
            r_nz_p1  <= w_nz;
            r_tag_p1 <= in_tag;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_dig   = r_dig_p1;
    assign out_nz    = r_nz_p1;
    assign out_tag   = r_tag_p1;

endmodule

// File: tb/tb_booth_enc_pipe.sv
// Directed and swept checks of the Booth recoder pipeline at WIDTH=16.
module tb_booth_enc_pipe;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int NDIG  = 9;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                in_signed;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [3*NDIG-1:0]   out_dig;
    logic [NDIG-1:0]     out_nz;
    logic [TAG_W-1:0]    out_tag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_enc_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dig   (out_dig),
        .out_nz    (out_nz),
        .out_tag   (out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one transaction for one edge, then sample at the following negedge.
    task automatic apply(input logic [WIDTH-1:0] d, input logic s, input logic [TAG_W-1:0] t);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        in_tag    = t;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3*NDIG-1:0] dig,
                           input logic [NDIG-1:0] nz, input logic [TAG_W-1:0] t);
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_dig"}, 64'(out_dig), 64'(dig));
        chk({tag, "_nz"},  64'(out_nz),  64'(nz));
        chk({tag, "_tag"}, 64'(out_tag), 64'(t));
    endtask

    // Independent decode: digit weights summed back into an integer.
    function automatic longint recon(input logic [3*NDIG-1:0] dig, output int bad,
                                     output logic [NDIG-1:0] nz);
        longint acc = 0;
        bad = 0;
        nz  = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            logic [2:0] c;
            longint     v;
            c = dig[3*k +: 3];
            case (c)
                3'b000:  v = 0;
                3'b001:  v = 1;
                3'b010:  v = 2;
                3'b101:  v = -1;
                3'b110:  v = -2;
                default: begin v = 0; bad++; end
            endcase
            nz[k] = (c != 3'b000);
            acc = acc * 4 + v;
        end
        return acc;
    endfunction

    initial begin
        logic [WIDTH-1:0] prev_d;
        logic             prev_s;
        longint           expv;
        longint           got;
        int               bad;
        logic [NDIG-1:0]  nzm;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
        #12;
        chk("rst_vld",   64'(out_valid), 64'd0);
        chk("rst_dig",   64'(out_dig),   64'd0);
        chk("rst_nz",    64'(out_nz),    64'd0);
        chk("rst_tag",   64'(out_tag),   64'd0);
        chk("rst_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed recoding vectors.
        apply(16'hFFFF, 1'b0, 4'h5); chk_out("u_ffff", 27'h1000005, 9'h101, 4'h5);
        apply(16'hFFFF, 1'b1, 4'h6); chk_out("s_ffff", 27'h0000005, 9'h001, 4'h6);
        apply(16'h8000, 1'b1, 4'h7); chk_out("s_8000", 27'h0C00000, 9'h080, 4'h7);
        apply(16'h8000, 1'b0, 4'h8); chk_out("u_8000", 27'h1C00000, 9'h180, 4'h8);
        apply(16'h0002, 1'b0, 4'h1); chk_out("u_0002", 27'h000000E, 9'h003, 4'h1);
        apply(16'h0002, 1'b1, 4'h2); chk_out("s_0002", 27'h000000E, 9'h003, 4'h2);
        apply(16'h7FFF, 1'b1, 4'h3); chk_out("s_7fff", 27'h0400005, 9'h081, 4'h3);
        apply(16'h0000, 1'b1, 4'hA); chk_out("s_0000", 27'h0000000, 9'h000, 4'hA);

        // Drain with no new input: valid drops, data holds.
        @(negedge clk); #1;
        chk("drain_vld", 64'(out_valid), 64'd0);
        chk("drain_tag", 64'(out_tag),   64'hA);

        // Backpressure: stall with a full stage and a pending input.
        apply(16'h0002, 1'b0, 4'h4);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 16'hFFFF; in_signed = 1'b0; in_tag = 4'h9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk_out("bp_hold", 27'h000000E, 9'h003, 4'h4);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_rel", 64'(in_ready), 64'd1);
        @(negedge clk); #1;
        chk_out("bp_new", 27'h1000005, 9'h101, 4'h9);
        in_valid = 1'b0;

        // Asynchronous reset mid-cycle, away from any rising edge.
        apply(16'h7FFF, 1'b1, 4'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(out_valid), 64'd0);
        chk("arst_dig", 64'(out_dig),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush overrides a capture and the input is dropped.
        apply(16'h0002, 1'b1, 4'h2);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF; in_signed = 1'b1; in_tag = 4'hE;
        #1;
        chk("fl_ready", 64'(in_ready), 64'd1);
        @(negedge clk); #1;
        chk("fl_vld", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;
        chk("fl_drop", 64'(out_valid), 64'd0);

        // Streaming sweep with mixed modes, one transaction per cycle.
        out_ready = 1'b1;
        prev_d = '0; prev_s = 1'b0;
        for (int i = 0; i <= 10000; i++) begin
            @(negedge clk); #1;
            if (i > 0) begin
                expv = prev_s ? longint'($signed(prev_d)) : longint'({48'd0, prev_d});
                got  = recon(out_dig, bad, nzm);
                chk("sw_vld",  64'(out_valid), 64'd1);
                chk("sw_sum",  64'(got),       64'(expv));
                chk("sw_code", 64'(bad),       64'd0);
                chk("sw_nz",   64'(out_nz),    64'(nzm));
                if (prev_s)
                    chk("sw_ext", 64'(out_dig[3*NDIG-1 -: 3]), 64'd0);
            end
            if (i < 10000) begin
                case (i)
                    0:       in_data = 16'hFFFF;
                    1:       in_data = 16'h8000;
                    2:       in_data = 16'h7FFF;
                    3:       in_data = 16'hAAAA;
                    default: in_data = 16'($urandom);
                endcase
                in_signed = 1'($urandom);
                in_tag    = 4'($urandom);
                in_valid  = 1'b1;
                prev_d    = in_data;
                prev_s    = in_signed;
            end else begin
                in_valid = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
